// File: rtl/jstk2_poll_ctrl.sv
// rtl/jstk2_poll_ctrl.sv - PmodJSTK2 poll scheduler: periodic 5-byte SPI exchange with atomic sample update
// Drives a byte-level SPI engine and publishes xpos/ypos/button together on sample_valid.
module jstk2_poll_ctrl #(
   parameter int POLL_CYCLES     = 600000,
   parameter int SS_SETUP_CYCLES = 180,
   parameter int BYTE_GAP_CYCLES = 120
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       led_en,
   input  logic [7:0] led_r,
   input  logic [7:0] led_g,
   input  logic [7:0] led_b,
   output logic       spi_start,
   output logic [7:0] spi_tx_byte,
   input  logic       spi_busy,
   input  logic       spi_done,
   input  logic [7:0] spi_rx_byte,
   output logic       ss,
   output logic [9:0] xpos,
   output logic [9:0] ypos,
   output logic [1:0] button,
   output logic       sample_valid
);

   localparam int PCW  = $clog2(POLL_CYCLES);
   localparam int WMAX = (SS_SETUP_CYCLES > BYTE_GAP_CYCLES) ? SS_SETUP_CYCLES : BYTE_GAP_CYCLES;
   localparam int WCW  = $clog2(WMAX + 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SETUP  = 3'd1;
   localparam logic [2:0] ST_SEND   = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_GAP    = 3'd4;
   localparam logic [2:0] ST_FINISH = 3'd5;

   logic [PCW-1:0]  poll_cnt_q, poll_cnt_d;
   logic [2:0]      state_q, state_d;
   logic [WCW-1:0]  wcnt_q, wcnt_d;
   logic [2:0]      idx_q, idx_d;
   logic            snap_led_q, snap_led_d;
   logic [7:0]      snap_r_q, snap_r_d;
   logic [7:0]      snap_g_q, snap_g_d;
   logic [7:0]      snap_b_q, snap_b_d;
   logic [4:0][7:0] rx_q, rx_d;
   logic            ss_q, ss_d;
   logic [9:0]      xpos_q, xpos_d;
   logic [9:0]      ypos_q, ypos_d;
   logic [1:0]      button_q, button_d;
   logic            sample_valid_q, sample_valid_d;
   logic            tick;
   logic [7:0]      tx_byte;

   assign tick = enable && (poll_cnt_q == PCW'(POLL_CYCLES - 1));

   always_comb begin
      poll_cnt_d = '0;
      if (enable && !tick) begin
         poll_cnt_d = poll_cnt_q + 1'b1;
      end
   end

   // setLedRGB is 0x84,R,G,B,0; a plain position read is 0xC0 followed by zeros.
   always_comb begin
      tx_byte = 8'h00;
      if (snap_led_q) begin
         case (idx_q)
            3'd0:    tx_byte = 8'h84;
            3'd1:    tx_byte = snap_r_q;
            3'd2:    tx_byte = snap_g_q;
            3'd3:    tx_byte = snap_b_q;
            default: tx_byte = 8'h00;
         endcase
      end else if (idx_q == 3'd0) begin
         tx_byte = 8'hC0;
      end
   end

   assign spi_start   = (state_q == ST_SEND) && !spi_busy;
   assign spi_tx_byte = spi_start ? tx_byte : 8'h00;

   always_comb begin
      state_d        = state_q;
      wcnt_d         = wcnt_q;
      idx_d          = idx_q;
      snap_led_d     = snap_led_q;
      snap_r_d       = snap_r_q;
      snap_g_d       = snap_g_q;
      snap_b_d       = snap_b_q;
      rx_d           = rx_q;
      ss_d           = ss_q;
      xpos_d         = xpos_q;
      ypos_d         = ypos_q;
      button_d       = button_q;
      sample_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tick) begin
               snap_led_d = led_en;
               snap_r_d   = led_r;
               snap_g_d   = led_g;
               snap_b_d   = led_b;
               ss_d       = 1'b0;
               wcnt_d     = '0;
               state_d    = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (wcnt_q == WCW'(SS_SETUP_CYCLES - 1)) begin
               wcnt_d  = '0;
               state_d = ST_SEND;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         ST_SEND: begin
            if (!spi_busy) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (spi_done) begin
               rx_d[idx_q] = spi_rx_byte;
               wcnt_d      = '0;
               state_d     = ST_GAP;
            end
         end
         ST_GAP: begin
            if (wcnt_q == WCW'(BYTE_GAP_CYCLES - 1)) begin
               wcnt_d = '0;
               if (idx_q == 3'd4) begin
                  ss_d    = 1'b1;
                  state_d = ST_FINISH;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ST_SEND;
               end
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         ST_FINISH: begin
            xpos_d         = {rx_q[1][1:0], rx_q[0]};
            ypos_d         = {rx_q[3][1:0], rx_q[2]};
            button_d       = rx_q[4][1:0];
            sample_valid_d = 1'b1;
            idx_d          = '0;
            state_d        = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         poll_cnt_q     <= '0;
         state_q        <= ST_IDLE;
         wcnt_q         <= '0;
         idx_q          <= '0;
         snap_led_q     <= 1'b0;
         snap_r_q       <= 8'h00;
         snap_g_q       <= 8'h00;
         snap_b_q       <= 8'h00;
         rx_q           <= '0;
         ss_q           <= 1'b1;
         xpos_q         <= 10'd512;
         ypos_q         <= 10'd512;
         button_q       <= 2'b00;
         sample_valid_q <= 1'b0;
      end else begin
         poll_cnt_q     <= poll_cnt_d;
         state_q        <= state_d;
         wcnt_q         <= wcnt_d;
         idx_q          <= idx_d;
         snap_led_q     <= snap_led_d;
         snap_r_q       <= snap_r_d;
         snap_g_q       <= snap_g_d;
         snap_b_q       <= snap_b_d;
         rx_q           <= rx_d;
         ss_q           <= ss_d;
         xpos_q         <= xpos_d;
         ypos_q         <= ypos_d;
         button_q       <= button_d;
         sample_valid_q <= sample_valid_d;
      end
   end

   assign ss           = ss_q;
   assign xpos         = xpos_q;
   assign ypos         = ypos_q;
   assign button       = button_q;
   assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_jstk2_poll_ctrl.sv
// tb/tb_jstk2_poll_ctrl.sv - directed bench for jstk2_poll_ctrl with a behavioural SPI byte engine
module tb_jstk2_poll_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       led_en;
   logic [7:0] led_r, led_g, led_b;
   logic       spi_start;
   logic [7:0] spi_tx_byte;
   logic       spi_busy;
   logic       spi_done = 1'b0;
   logic [7:0] spi_rx_byte = 8'h00;
   logic       ss;
   logic [9:0] xpos, ypos;
   logic [1:0] button;
   logic       sample_valid;

   always #5 clk = ~clk;

   jstk2_poll_ctrl #(
      .POLL_CYCLES(1000),
      .SS_SETUP_CYCLES(4),
      .BYTE_GAP_CYCLES(3)
   ) u_dut (
      .clk(clk), .rst(rst), .enable(enable), .led_en(led_en),
      .led_r(led_r), .led_g(led_g), .led_b(led_b),
      .spi_start(spi_start), .spi_tx_byte(spi_tx_byte), .spi_busy(spi_busy),
      .spi_done(spi_done), .spi_rx_byte(spi_rx_byte), .ss(ss),
      .xpos(xpos), .ypos(ypos), .button(button), .sample_valid(sample_valid)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge clk) cyc++;

   // Event monitor, sampled on the falling edge.
   int         n_ss_fall = 0, n_start = 0, n_sv = 0, n_bad_chg = 0;
   int         ss_fall_cyc = 0;
   int         start_cyc[$];
   logic [7:0] txq[$];
   logic       ss_prev = 1'b1;
   logic [9:0] x_prev = 10'd512, y_prev = 10'd512, fall_x = 10'd0;
   logic [1:0] b_prev = 2'b00;
   logic [9:0] sv_x = 10'd0, sv_y = 10'd0;
   logic [1:0] sv_b = 2'b00;
   logic       sv_ss = 1'b0;

   always @(negedge clk) begin
      if (ss_prev && !ss) begin
         n_ss_fall++;
         ss_fall_cyc = cyc;
         fall_x = xpos;
      end
      ss_prev = ss;
      if (spi_start) begin
         n_start++;
         txq.push_back(spi_tx_byte);
         start_cyc.push_back(cyc);
      end
      if (sample_valid) begin
         n_sv++;
         sv_x  = xpos;
         sv_y  = ypos;
         sv_b  = button;
         sv_ss = ss;
      end
      if (!rst && !sample_valid && (xpos !== x_prev || ypos !== y_prev || button !== b_prev))
         n_bad_chg++;
      x_prev = xpos;
      y_prev = ypos;
      b_prev = button;
   end

   // SPI engine model: busy after a start, done 16 cycles later with the next table byte.
   logic       mdl_busy = 1'b0;
   logic       force_busy = 1'b0;
   logic       stray_now = 1'b0;
   int         mdl_cnt = 0, rx_idx = 0, m_seen = 0, stray_req = 0, stray_served = 0;
   logic [7:0] rx_tbl [5];

   assign spi_busy = mdl_busy | force_busy;

   always begin
      @(posedge clk);
      #1;
      spi_done = 1'b0;
      if (rst) begin
         mdl_busy  = 1'b0;
         mdl_cnt   = 0;
         rx_idx    = 0;
         m_seen    = n_start;
         stray_now = 1'b0;
      end else if (stray_now) begin
         spi_done    = 1'b1;
         spi_rx_byte = 8'hEE;
         stray_now   = 1'b0;
      end else if (mdl_cnt != 0) begin
         mdl_cnt--;
         if (mdl_cnt == 0) begin
            spi_done    = 1'b1;
            mdl_busy    = 1'b0;
            spi_rx_byte = rx_tbl[rx_idx];
            rx_idx      = (rx_idx + 1) % 5;
            if (stray_req != stray_served) begin
               stray_served++;
               stray_now = 1'b1;
            end
         end
      end else if (n_start != m_seen) begin
         m_seen   = n_start;
         mdl_busy = 1'b1;
         mdl_cnt  = 16;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_tx(input string tag, input int base,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4);
      logic [7:0] e [5];
      e = '{b0, b1, b2, b3, b4};
      for (int i = 0; i < 5; i++)
         chk($sformatf("%s_tx%0d", tag, i),
             (base + i < txq.size()) ? 32'(txq[base + i]) : 32'hFFFF_FFFF, 32'(e[i]));
   endtask

   task automatic wait_ss_fall(input int target);
      int g = 0;
      while (n_ss_fall < target && g < 1100) begin
         tick(1);
         g++;
      end
      chk($sformatf("ss_fall_%0d_seen", target), n_ss_fall, target);
   endtask

   task automatic wait_sv(input int target);
      int g = 0;
      while (n_sv < target && g < 400) begin
         tick(1);
         g++;
      end
      chk($sformatf("sample_valid_%0d_seen", target), n_sv, target);
   endtask

   task automatic wait_start(input int target);
      int g = 0;
      while (n_start < target && g < 300) begin
         tick(1);
         g++;
      end
      chk($sformatf("start_%0d_seen", target), n_start, target);
   endtask

   int t0, fall_prev, base, s0;

   initial begin
      rst = 1'b1; enable = 1'b0; led_en = 1'b0;
      led_r = 8'h00; led_g = 8'h00; led_b = 8'h00;
      rx_tbl = '{8'hFF, 8'h03, 8'h00, 8'h00, 8'h01};
      tick(3);
      chk("rst_ss", 32'(ss), 1);
      chk("rst_spi_start", 32'(spi_start), 0);
      chk("rst_tx_byte", 32'(spi_tx_byte), 0);
      chk("rst_xpos", 32'(xpos), 512);
      chk("rst_ypos", 32'(ypos), 512);
      chk("rst_button", 32'(button), 0);
      chk("rst_sample_valid", 32'(sample_valid), 0);
      rst = 1'b0;
      tick(5);
      chk("disabled_no_ss_fall", n_ss_fall, 0);

      // Plain position read, rx 0xFF,0x03,0x00,0x00,0x01
      enable = 1'b1;
      t0 = cyc;
      wait_ss_fall(1);
      chk("t1_ss_delay", ss_fall_cyc - t0, 1000);
      chk("t1_xpos_before", 32'(fall_x), 512);
      fall_prev = ss_fall_cyc;
      wait_sv(1);
      chk("t1_start_count", n_start, 5);
      chk("t1_setup_delay", (start_cyc.size() > 0) ? start_cyc[0] - fall_prev : -1, 4);
      chk_tx("t1", 0, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00);
      chk("t1_ss_high_at_sv", 32'(sv_ss), 1);
      chk("t1_xpos", 32'(sv_x), 1023);
      chk("t1_ypos", 32'(sv_y), 0);
      chk("t1_button", 32'(sv_b), 1);

      // LED command; R changes after the snapshot
      led_en = 1'b1; led_r = 8'h10; led_g = 8'h20; led_b = 8'h30;
      rx_tbl = '{8'h34, 8'hFE, 8'h78, 8'h01, 8'h06};
      wait_ss_fall(2);
      chk("t2_period", ss_fall_cyc - fall_prev, 1000);
      fall_prev = ss_fall_cyc;
      base = n_start;
      tick(2);
      led_r = 8'h99;
      wait_sv(2);
      chk("t2_start_count", n_start, base + 5);
      chk_tx("t2", base, 8'h84, 8'h10, 8'h20, 8'h30, 8'h00);
      chk("t2_xpos", 32'(sv_x), 564);
      chk("t2_ypos", 32'(sv_y), 376);
      chk("t2_button", 32'(sv_b), 2);
      chk("t2_sv_single", n_sv, 2);

      // Busy stall in SEND plus a stray done in GAP
      wait_ss_fall(3);
      chk("t3_period", ss_fall_cyc - fall_prev, 1000);
      base = n_start;
      wait_start(base + 1);
      force_busy = 1'b1;
      s0 = n_start;
      tick(70);
      chk("t3_no_start_while_busy", n_start, s0);
      stray_req++;
      force_busy = 1'b0;
      wait_sv(3);
      chk("t3_stray_issued", stray_served, 1);
      chk("t3_start_count", n_start, base + 5);
      chk_tx("t3", base, 8'h84, 8'h99, 8'h20, 8'h30, 8'h00);
      chk("t3_xpos", 32'(sv_x), 564);
      chk("t3_ypos", 32'(sv_y), 376);
      chk("t3_button", 32'(sv_b), 2);

      // Reset during byte 2
      wait_ss_fall(4);
      base = n_start;
      wait_start(base + 3);
      tick(3);
      rst = 1'b1;
      #1;
      chk("t4_rst_ss", 32'(ss), 1);
      chk("t4_rst_xpos", 32'(xpos), 512);
      chk("t4_rst_ypos", 32'(ypos), 512);
      chk("t4_rst_button", 32'(button), 0);
      chk("t4_rst_spi_start", 32'(spi_start), 0);
      s0 = n_start;
      tick(3);
      chk("t4_no_start_in_rst", n_start, s0);
      rst = 1'b0;
      t0 = cyc;
      wait_ss_fall(5);
      chk("t4_restart_delay", ss_fall_cyc - t0, 1000);
      chk("t4_xpos_before", 32'(fall_x), 512);

      // Enable drops during byte 3
      base = n_start;
      wait_start(base + 4);
      enable = 1'b0;
      wait_sv(4);
      chk("t5_start_count", n_start, base + 5);
      chk("t5_xpos", 32'(sv_x), 564);
      chk("t5_button", 32'(sv_b), 2);
      tick(2500);
      chk("t5_no_more_ss_fall", n_ss_fall, 5);
      chk("t5_sv_count", n_sv, 4);
      chk("t5_xpos_hold", 32'(xpos), 564);
      enable = 1'b1;
      t0 = cyc;
      wait_ss_fall(6);
      chk("t5_reenable_delay", ss_fall_cyc - t0, 1000);
      wait_sv(5);
      chk("outputs_only_change_on_sv", n_bad_chg, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
